dma_mc_fifo: RTL

- Multi-channel successor of the single-queue DMA data FIFO.
- CHANNELS independent first-word-fall-through queues share one write port, steered by a channel index. Each channel has its own valid/ready read port.
- Used between the DMA read engine (one beat per cycle, any channel) and per-channel write engines.
- Adds per-channel occupancy, almost-full threshold, per-channel clear and rejection of illegal channel indices.

---
 rtl/dma_mc_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dma_mc_fifo.sv
// Multi-channel FWFT DMA data FIFO: CHANNELS queues of SLOTS beats share one steered write port.
// Latency: push visible on rd_*_o next cycle; flags/count registered-state derived (1 cycle).
// Backpressure: wr_ready_o drops for full/clearing/illegal channel; per-channel valid/ready reads.
// Optional error flags: define DMA_MC_FIFO_ERR_EN.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

module dma_mc_fifo #(
    parameter int CHANNELS  = 4,
    parameter int SLOTS     = 16,
    parameter int WIDTH     = `DMA_DATA_WIDTH,
    parameter int AFULL_THR = SLOTS - 2,
    localparam int CW       = $clog2(CHANNELS > 1 ? CHANNELS : 2),
    localparam int PW       = $clog2(SLOTS)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [CHANNELS-1:0]          clear_i,
    input  logic                         wr_valid_i,
    input  logic [CW-1:0]                wr_ch_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    output logic                         wr_ready_o,
    output logic [CHANNELS-1:0]          rd_valid_o,
    input  logic [CHANNELS-1:0]          rd_ready_i,
    output logic [CHANNELS*WIDTH-1:0]    rd_data_o,
    output logic [CHANNELS*(PW+1)-1:0]   count_o,
    output logic [CHANNELS-1:0]          full_o,
    output logic [CHANNELS-1:0]          afull_o,
`ifdef DMA_MC_FIFO_ERR_EN
    output logic [CHANNELS-1:0]          err_ovf_o,
    output logic [CHANNELS-1:0]          err_udf_o,
`endif
    output logic [CHANNELS-1:0]          empty_o
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("dma_mc_fifo: CHANNELS must be >= 1");
    end
    if (SLOTS < 2 || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
        $error("dma_mc_fifo: SLOTS must be a power of 2 and >= 2");
    end
    if (AFULL_THR < 1 || AFULL_THR > SLOTS) begin : g_bad_afull
        $error("dma_mc_fifo: AFULL_THR must be in 1..SLOTS");
    end

    logic [PW:0]       wptr_q [CHANNELS];
    logic [PW:0]       wptr_d [CHANNELS];
    logic [PW:0]       rptr_q [CHANNELS];
    logic [PW:0]       rptr_d [CHANNELS];
    logic [WIDTH-1:0]  mem_q  [CHANNELS][SLOTS];
    logic [PW:0]       cnt    [CHANNELS];
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic              ch_in_range;
    logic              ch_can_take;

    assign ch_in_range = ({1'b0, wr_ch_i} < (CW+1)'(CHANNELS));

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cnt[c]     = wptr_q[c] - rptr_q[c];
            empty_o[c] = (wptr_q[c] == rptr_q[c]);
            full_o[c]  = (wptr_q[c][PW-1:0] == rptr_q[c][PW-1:0]) &&
                         (wptr_q[c][PW] != rptr_q[c][PW]);
            afull_o[c] = (cnt[c] >= (PW+1)'(AFULL_THR));
        end
    end

    assign rd_valid_o = ~empty_o;

    // rstn gates readiness so no beat is accepted while the block is held in reset.
    always_comb begin
        ch_can_take = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_ch_i == CW'(c)) begin
                ch_can_take = !full_o[c] && !clear_i[c];
            end
        end
        wr_ready_o = rstn && ch_in_range && ch_can_take;
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            push[c]   = wr_valid_i && wr_ready_o && (wr_ch_i == CW'(c));
            pop[c]    = !empty_o[c] && rd_ready_i[c];
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            if (clear_i[c]) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
            end else begin
                if (push[c]) wptr_d[c] = wptr_q[c] + 1'b1;
                if (pop[c])  rptr_d[c] = rptr_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) mem_q[c][wptr_q[c][PW-1:0]] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        count_o   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            count_o[c*(PW+1) +: (PW+1)] = cnt[c];
            if (!empty_o[c]) rd_data_o[c*WIDTH +: WIDTH] = mem_q[c][rptr_q[c][PW-1:0]];
        end
    end

`ifdef DMA_MC_FIFO_ERR_EN
    logic [CHANNELS-1:0] ovf_q, ovf_d, udf_q, udf_d;

    // Illegal channel indices are charged to channel 0's overflow flag.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_valid_i && (wr_ch_i == CW'(c)) && full_o[c]) ovf_d[c] = 1'b1;
            if (rd_ready_i[c] && empty_o[c]) udf_d[c] = 1'b1;
        end
        if (wr_valid_i && !ch_in_range) ovf_d[0] = 1'b1;
        ovf_d = ovf_d & ~clear_i;
        udf_d = udf_d & ~clear_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign err_ovf_o = ovf_q;
    assign err_udf_o = udf_q;
`endif

endmodule
